// File: rtl/l2_stream_fill.sv
// l2_stream_fill: issues host reads for stream line requests, writes the
// returned lines into L2 slots (responses may arrive out of order), and
// notifies the stream pointer of filled lines strictly in request order.
//
// Handshake rule for every *_v/*_r pair: a transfer happens on a rising
// clock edge where valid and ready are both high. The valid side holds its
// payload until then. o_wr_v is a bare strobe with no ready.
module l2_stream_fill #(
    parameter int addr_width       = 64,
    parameter int cache_line       = 128,
    parameter int cache_line_width = $clog2(cache_line),
    parameter int l2_ncl           = 256,
    parameter int l2_ncl_width     = $clog2(l2_ncl),
    parameter int ntag             = 32,
    parameter int tag_width        = $clog2(ntag),
    parameter int cnt_width        = $clog2(ntag + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_rst_v,
    output logic                      i_rst_r,
    input  logic [addr_width-1:0]     i_rst_ea,
    input  logic                      i_req_v,
    output logic                      i_req_r,
    input  logic [addr_width-1:0]     i_req_ea,
    output logic                      o_hreq_v,
    input  logic                      o_hreq_r,
    output logic [addr_width-1:0]     o_hreq_ea,
    output logic [tag_width-1:0]      o_hreq_tag,
    input  logic                      i_hrsp_v,
    output logic                      i_hrsp_r,
    input  logic [tag_width-1:0]      i_hrsp_tag,
    input  logic [cache_line*8-1:0]   i_hrsp_d,
    output logic                      o_wr_v,
    output logic [l2_ncl_width-1:0]   o_wr_ptr,
    output logic [cache_line*8-1:0]   o_wr_d,
    output logic                      o_rsp_v,
    input  logic                      o_rsp_r,
    output logic                      o_err
);

    localparam logic [cnt_width-1:0] full_cnt = cnt_width'(ntag);

    logic [tag_width-1:0]    head;
    logic [tag_width-1:0]    tail;
    logic [cnt_width-1:0]    outstanding;
    logic [l2_ncl_width-1:0] wr_ptr;
    logic [l2_ncl_width-1:0] slot [ntag];
    logic [ntag-1:0]         done;

    logic                    not_full;
    logic                    req_acc;
    logic                    rsp_acc;
    logic                    rst_acc;
    logic [tag_width-1:0]    rsp_off;
    logic                    in_flight;
    logic                    rsp_ok;
    logic                    rsp_bad;

    // Address bits below the line offset and above the slot index are not
    // needed to pick the starting slot.
    logic unused_ea_bits;
    assign unused_ea_bits = ^{i_rst_ea[addr_width-1:l2_ncl_width+cache_line_width],
                              i_rst_ea[cache_line_width-1:0]};

    // Requests pass straight through to the host; a pending functional reset
    // or a full tag window blocks them.
    assign not_full   = (outstanding != full_cnt);
    assign o_hreq_v   = i_req_v & ~i_rst_v & not_full;
    assign i_req_r    = o_hreq_r & ~i_rst_v & not_full;
    assign o_hreq_ea  = i_req_ea;
    assign o_hreq_tag = head;
    assign req_acc    = i_req_v & i_req_r;

    // Responses are always taken; bad ones only raise the sticky error.
    assign i_hrsp_r  = 1'b1;
    assign rsp_off   = i_hrsp_tag - tail;
    assign in_flight = (cnt_width'(rsp_off) < outstanding);
    assign rsp_ok    = i_hrsp_v & in_flight & ~done[i_hrsp_tag];
    assign rsp_bad   = i_hrsp_v & ~rsp_ok;

    // In-order retirement: the oldest tag is reported once its line is written.
    assign o_rsp_v = done[tail];
    assign rsp_acc = o_rsp_v & o_rsp_r;

    // A stream restart may only be taken once every line has retired.
    assign i_rst_r = (outstanding == '0);
    assign rst_acc = i_rst_v & i_rst_r;

    // Remember which L2 slot each issued tag fills (no reset needed).
    always_ff @(posedge clk) begin
        if (req_acc) begin
            slot[head] <= wr_ptr;
        end
    end

    // Pointer and occupancy bookkeeping for the tag window.
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (rst_acc) begin
                wr_ptr <= i_rst_ea[l2_ncl_width+cache_line_width-1:cache_line_width];
                head   <= '0;
                tail   <= '0;
            end else begin
                if (req_acc) begin
                    head   <= head + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rsp_acc) begin
                    tail <= tail + 1'b1;
                end
            end
            case ({req_acc, rsp_acc})
                2'b10:   outstanding <= outstanding + cnt_width'(1);
                2'b01:   outstanding <= outstanding - cnt_width'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Per-tag "line written" flags; set by a good response, cleared on retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= '0;
        end else begin
            if (rsp_ok) begin
                done[i_hrsp_tag] <= 1'b1;
            end
            if (rsp_acc) begin
                done[tail] <= 1'b0;
            end
        end
    end

    // Registered L2 write port: one-cycle strobe per good response.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_wr_v   <= 1'b0;
            o_wr_ptr <= '0;
            o_wr_d   <= '0;
        end else begin
            o_wr_v <= rsp_ok;
            if (rsp_ok) begin
                o_wr_ptr <= slot[i_hrsp_tag];
                o_wr_d   <= i_hrsp_d;
            end
        end
    end

    // Sticky protocol error, cleared only by reset or an accepted stream restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err <= 1'b0;
        end else begin
            o_err <= (o_err & ~rst_acc) | rsp_bad;
        end
    end

endmodule

// File: tb/tb_l2_stream_fill.sv
// Directed testbench for l2_stream_fill: a per-cycle vector table followed by
// hand-written sequences for tag-window fill, wrap and mid-flight reset.
module tb_l2_stream_fill;

    logic          clk;
    logic          reset;
    logic          i_rst_v;
    logic          i_rst_r;
    logic [63:0]   i_rst_ea;
    logic          i_req_v;
    logic          i_req_r;
    logic [63:0]   i_req_ea;
    logic          o_hreq_v;
    logic          o_hreq_r;
    logic [63:0]   o_hreq_ea;
    logic [4:0]    o_hreq_tag;
    logic          i_hrsp_v;
    logic          i_hrsp_r;
    logic [4:0]    i_hrsp_tag;
    logic [1023:0] i_hrsp_d;
    logic          o_wr_v;
    logic [7:0]    o_wr_ptr;
    logic [1023:0] o_wr_d;
    logic          o_rsp_v;
    logic          o_rsp_r;
    logic          o_err;

    int vectors;
    int miscompares;

    l2_stream_fill dut (
        .clk        (clk),
        .reset      (reset),
        .i_rst_v    (i_rst_v),
        .i_rst_r    (i_rst_r),
        .i_rst_ea   (i_rst_ea),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_ea   (i_req_ea),
        .o_hreq_v   (o_hreq_v),
        .o_hreq_r   (o_hreq_r),
        .o_hreq_ea  (o_hreq_ea),
        .o_hreq_tag (o_hreq_tag),
        .i_hrsp_v   (i_hrsp_v),
        .i_hrsp_r   (i_hrsp_r),
        .i_hrsp_tag (i_hrsp_tag),
        .i_hrsp_d   (i_hrsp_d),
        .o_wr_v     (o_wr_v),
        .o_wr_ptr   (o_wr_ptr),
        .o_wr_d     (o_wr_d),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_err      (o_err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_v;
        logic [63:0] rst_ea;
        logic        req_v;
        logic        hrsp_v;
        logic [4:0]  hrsp_tag;
        logic [31:0] hrsp_seed;
        logic        rsp_r;
        logic        e_hreq_v;
        logic        e_req_r;
        logic [4:0]  e_tag;
        logic        e_rst_r;
        logic        e_wr_v;
        logic [7:0]  e_wr_ptr;
        logic [31:0] e_wr_seed;
        logic        e_rsp_v;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rv, input logic [63:0] rea, input logic qv,
                                input logic hv, input int ht, input logic [31:0] hs,
                                input logic rr, input logic ehv, input logic erq,
                                input int et, input logic errdy, input logic ewv,
                                input int ep, input logic [31:0] es, input logic erv,
                                input logic eerr);
        vec_t v;
        v.rst_v     = rv;
        v.rst_ea    = rea;
        v.req_v     = qv;
        v.hrsp_v    = hv;
        v.hrsp_tag  = 5'(ht);
        v.hrsp_seed = hs;
        v.rsp_r     = rr;
        v.e_hreq_v  = ehv;
        v.e_req_r   = erq;
        v.e_tag     = 5'(et);
        v.e_rst_r   = errdy;
        v.e_wr_v    = ewv;
        v.e_wr_ptr  = 8'(ep);
        v.e_wr_seed = es;
        v.e_rsp_v   = erv;
        v.e_err     = eerr;
        return v;
    endfunction

    // Driver tasks
    task automatic idle();
        i_rst_v    = 1'b0;
        i_rst_ea   = '0;
        i_req_v    = 1'b0;
        i_req_ea   = 64'h1000_0000;
        o_hreq_r   = 1'b1;
        i_hrsp_v   = 1'b0;
        i_hrsp_tag = '0;
        i_hrsp_d   = '0;
        o_rsp_r    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard for one table vector
    task automatic check_vec(input int idx, input vec_t v);
        logic [10:0] got;
        logic [10:0] exp;
        logic        bad;
        got = {o_hreq_v, i_req_r, o_hreq_tag, i_rst_r, o_wr_v, o_rsp_v, o_err};
        exp = {v.e_hreq_v, v.e_req_r, v.e_tag, v.e_rst_r, v.e_wr_v, v.e_rsp_v, v.e_err};
        bad = (got !== exp) || (o_hreq_ea !== i_req_ea) || (i_hrsp_r !== 1'b1);
        if (v.e_wr_v && ((o_wr_ptr !== v.e_wr_ptr) || (o_wr_d !== {32{v.e_wr_seed}})))
            bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL vec%0d: got {hreq_v,req_r,tag,rst_r,wr_v,rsp_v,err}=%b wr_ptr=%0d wr_d[31:0]=%h, expected %b wr_ptr=%0d wr_d[31:0]=%h",
                     idx, got, o_wr_ptr, o_wr_d[31:0], exp, v.e_wr_ptr, v.e_wr_seed);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // rst ea  req  hv tag seed        rr  | hv rr tag rrdy wv ptr seed        rv err
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(1, 64'h1000_0380,  1, 0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          1, 0, 0, 32'h0,        0, 1, 1, 0, 1, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          1, 0, 0, 32'h0,        0, 1, 1, 1, 0, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          1, 0, 0, 32'h0,        0, 1, 1, 2, 0, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          0, 1, 2, 32'hA2A2_0002, 0, 0, 1, 3, 0, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          0, 1, 0, 32'hA0A0_0000, 1, 0, 1, 3, 0, 1, 9,   32'hA2A2_0002, 0, 0));
        tbl.push_back(mk(0, 64'h0,          0, 1, 1, 32'hA1A1_0001, 1, 0, 1, 3, 0, 1, 7,   32'hA0A0_0000, 1, 0));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        1, 0, 1, 3, 0, 1, 8,   32'hA1A1_0001, 1, 0));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        0, 0, 1, 3, 0, 0, 0,   32'h0,        1, 0));
        tbl.push_back(mk(1, 64'h0,          0, 0, 0, 32'h0,        1, 0, 0, 3, 0, 0, 0,   32'h0,        1, 0));
        tbl.push_back(mk(1, 64'h7F80,       0, 0, 0, 32'h0,        0, 0, 0, 3, 1, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          1, 0, 0, 32'h0,        0, 1, 1, 0, 1, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          1, 0, 0, 32'h0,        0, 1, 1, 1, 0, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          0, 1, 5, 32'hDEAD_0005, 0, 0, 1, 2, 0, 0, 0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 64'h0,          0, 1, 1, 32'hB1B1_0001, 0, 0, 1, 2, 0, 0, 0,   32'h0,        0, 1));
        tbl.push_back(mk(0, 64'h0,          0, 1, 0, 32'hB0B0_0000, 0, 0, 1, 2, 0, 1, 0,   32'hB1B1_0001, 0, 1));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        0, 0, 1, 2, 0, 1, 255, 32'hB0B0_0000, 1, 1));
        tbl.push_back(mk(0, 64'h0,          0, 1, 1, 32'hEEEE_0001, 0, 0, 1, 2, 0, 0, 0,   32'h0,        1, 1));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        1, 0, 1, 2, 0, 0, 0,   32'h0,        1, 1));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        1, 0, 1, 2, 0, 0, 0,   32'h0,        1, 1));
        tbl.push_back(mk(1, 64'h0,          0, 0, 0, 32'h0,        0, 0, 0, 2, 1, 0, 0,   32'h0,        0, 1));
        tbl.push_back(mk(0, 64'h0,          0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 0,   32'h0,        0, 0));

        // Table-driven phase: one record per clock cycle
        for (int i = 0; i < tbl.size(); i++) begin
            i_rst_v    = tbl[i].rst_v;
            i_rst_ea   = tbl[i].rst_ea;
            i_req_v    = tbl[i].req_v;
            i_req_ea   = 64'h1000_0380 + 64'(i) * 64'd128;
            o_hreq_r   = 1'b1;
            i_hrsp_v   = tbl[i].hrsp_v;
            i_hrsp_tag = tbl[i].hrsp_tag;
            i_hrsp_d   = {32{tbl[i].hrsp_seed}};
            o_rsp_r    = tbl[i].rsp_r;
            @(negedge clk);
            check_vec(i, tbl[i]);
            next_cycle();
        end
        idle();

        // Fill the whole tag window with no responses
        for (int i = 0; i < 32; i++) begin
            i_req_v = 1'b1;
            @(negedge clk);
            check("fill_tag", 64'(o_hreq_tag), 64'(i));
            check("fill_hs", {62'd0, o_hreq_v, i_req_r}, 64'd3);
            next_cycle();
        end
        @(negedge clk);
        check("full_blocks_req", {62'd0, o_hreq_v, i_req_r}, 64'd0);
        next_cycle();

        // Answer tags 0 and 1, then retire tag 0 while a request waits
        i_req_v    = 1'b0;
        i_hrsp_v   = 1'b1;
        i_hrsp_tag = 5'd0;
        i_hrsp_d   = {32{32'hC0C0_0000}};
        @(negedge clk);
        check("full_no_early_wr", {63'd0, o_wr_v}, 64'd0);
        next_cycle();
        i_hrsp_tag = 5'd1;
        i_hrsp_d   = {32{32'hC1C1_0001}};
        @(negedge clk);
        check("full_wr_tag0", {55'd0, o_wr_v, o_wr_ptr}, {55'd0, 1'b1, 8'd0});
        check("full_wr_d0", 64'(o_wr_d[31:0]), 64'h0000_0000_C0C0_0000);
        check("full_rsp_v", {63'd0, o_rsp_v}, 64'd1);
        next_cycle();
        i_hrsp_v = 1'b0;
        o_rsp_r  = 1'b1;
        i_req_v  = 1'b1;
        @(negedge clk);
        check("full_retire_cycle", {62'd0, i_req_r, o_rsp_v}, 64'd1);
        next_cycle();
        @(negedge clk);
        check("wrap_tag0", {58'd0, i_req_r, o_hreq_tag}, {58'd0, 1'b1, 5'd0});
        next_cycle();
        o_rsp_r = 1'b0;
        @(negedge clk);
        check("wrap_tag1", {58'd0, i_req_r, o_hreq_tag}, {58'd0, 1'b1, 5'd1});
        next_cycle();
        @(negedge clk);
        check("accept_retire_keeps_cnt", {63'd0, i_req_r}, 64'd0);
        next_cycle();

        // Synchronous reset while full, with traffic on every handshake
        reset      = 1'b1;
        o_rsp_r    = 1'b1;
        i_hrsp_v   = 1'b1;
        i_hrsp_tag = 5'd3;
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("post_reset_state", {56'd0, i_rst_r, o_hreq_tag, o_wr_v, o_err},
              {56'd0, 1'b1, 5'd0, 1'b0, 1'b0});
        check("post_reset_ptr", {55'd0, o_rsp_v, o_wr_ptr}, 64'd0);
        next_cycle();
        i_hrsp_v   = 1'b1;
        i_hrsp_tag = 5'd3;
        next_cycle();
        idle();
        @(negedge clk);
        check("stale_rsp_err", {62'd0, o_wr_v, o_err}, 64'd1);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_stream_fill.md
L2_STREAM_FILL -- requirements
Module: l2_stream_fill

Interface
REQ-001 SHALL have parameters: addr_width=64, host address bits; cache_line=128, line size in bytes; cache_line_width=$clog2(cache_line); l2_ncl=256, L2 lines per stream; l2_ncl_width=$clog2(l2_ncl); ntag=32, max outstanding host requests (power of two); tag_width=$clog2(ntag); cnt_width=$clog2(ntag+1).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk in 1: single clock.
- reset in 1: synchronous, active-high.
- i_rst_v in 1 / i_rst_r out 1: functional stream reset handshake.
- i_rst_ea in addr_width: new stream start address.
- i_req_v in 1 / i_req_r out 1: line request from the stream pointer.
- i_req_ea in addr_width: requested line address.
- o_hreq_v out 1 / o_hreq_r in 1: host read request.
- o_hreq_ea out addr_width: host request address.
- o_hreq_tag out tag_width: host request tag.
- i_hrsp_v in 1 / i_hrsp_r out 1: host response; responses may return out of order.
- i_hrsp_tag in tag_width: response tag.
- i_hrsp_d in cache_line*8: response line data.
- o_wr_v out 1: L2 URAM write enable; no backpressure.
- o_wr_ptr out l2_ncl_width: URAM line slot.
- o_wr_d out cache_line*8: URAM write data.
- o_rsp_v out 1 / o_rsp_r in 1: in-order line-filled notification to the stream pointer.
- o_err out 1: sticky protocol error.

Function
REQ-003 Request path SHALL be combinational pass-through: o_hreq_v = i_req_v & ~i_rst_v & (outstanding < ntag); i_req_r = o_hreq_r & ~i_rst_v & (outstanding < ntag); o_hreq_ea = i_req_ea; o_hreq_tag = head.
REQ-004 Accepted request (i_req_v & i_req_r) SHALL store slot[head] = wr_ptr, then increment head (mod ntag), wr_ptr (mod l2_ncl) and outstanding.
REQ-005 i_hrsp_r SHALL be constant 1.
REQ-006 Valid response for an in-flight, not-done tag SHALL register o_wr_v=1, o_wr_ptr=slot[tag], o_wr_d=i_hrsp_d and set done[tag] at the same edge; o_wr_v SHALL be high exactly one cycle (1-cycle latency).
REQ-007 Response for a tag not in flight (outside tail..head-1) or already done SHALL cause no write and no state change, except setting o_err.
REQ-008 o_rsp_v SHALL equal done[tail]; on o_rsp_v & o_rsp_r, clear done[tail], increment tail, decrement outstanding.
REQ-009 o_rsp_v for a line SHALL never assert before that line's o_wr_v cycle; notifications SHALL be in request order regardless of response order.
REQ-010 Request accept and retire in the same cycle SHALL leave outstanding unchanged; response and retire of different tags in the same cycle SHALL both take effect.
REQ-011 outstanding SHALL range 0..ntag; at ntag, i_req_r=0 and o_hreq_v=0.
REQ-012 i_rst_r SHALL be (outstanding==0); an accepted functional reset SHALL set wr_ptr = i_rst_ea[l2_ncl_width+cache_line_width-1:cache_line_width], head=tail=0, and clear o_err.
REQ-013 While i_rst_v=1, no new request SHALL be accepted, even if i_rst_r=0.

Reset
REQ-014 On reset=1 at a clock edge: head=tail=wr_ptr=0, outstanding=0, all done=0, o_wr_v=0, o_rsp_v=0, o_err=0, o_wr_ptr=0, o_wr_d=0; slot contents don't-care.
REQ-015 reset SHALL override all concurrent handshakes, including mid-flight requests; in-flight responses after reset are treated per REQ-007.

Verification
REQ-016 Functional reset with ea=0x1000_0380 and 0 outstanding -> i_rst_r=1; next accepted request issues with tag 0; its response writes o_wr_ptr=0x07.
REQ-017 3 requests, responses in tag order 2,0,1 -> o_wr_v for slots s+2, s, s+1; o_rsp_v pulses 3 times, first only after tag 0 is written.
REQ-018 32 accepted requests with no responses -> i_req_r=0 and o_hreq_v=0 on the 33rd; one retire -> next request issues with tag 0.
REQ-019 Response with tag 5 while only tags 0..2 are in flight -> o_wr_v stays 0, o_err=1, and remains 1 until reset or functional reset.
REQ-020 i_rst_v with 1 outstanding -> i_rst_r=0 and i_req_r=0 until the retire, then the reset is accepted the following cycle.
REQ-021 wr_ptr at 255 after request accept -> next slot is 0 (wrap); with o_rsp_r held 0, done lines stay pending and o_rsp_v stays 1.
